// File: rtl/fp_rs_pkg.sv
// Shared types and helpers for the FP-adder reservation station.
package fp_rs_pkg;

    localparam int DEF_TAG_W   = 4;
    localparam logic [DEF_TAG_W-1:0] NO_TAG = '0;
    localparam int FP_SIGN_BIT = 31;

    // One reservation-station slot. A zero producer tag means the value
    // field already holds the operand.
    typedef struct packed {
        logic                 valid;
        logic [DEF_TAG_W-1:0] tag;
        logic                 sub;
        logic [DEF_TAG_W-1:0] qj;
        logic [31:0]          vj;
        logic [DEF_TAG_W-1:0] qk;
        logic [31:0]          vk;
    } rs_entry_t;

    // True when the bus broadcast resolves a pending producer tag.
    function automatic logic tag_hit(input logic                 bus_valid,
                                     input logic [DEF_TAG_W-1:0] bus_tag,
                                     input logic [DEF_TAG_W-1:0] q);
        return bus_valid && (q != NO_TAG) && (bus_tag == q);
    endfunction

    // Subtraction is done on the adder by negating operand b.
    function automatic logic [31:0] sign_flip(input logic [31:0] v,
                                              input logic        sub);
        return {v[FP_SIGN_BIT] ^ sub, v[FP_SIGN_BIT-1:0]};
    endfunction

endpackage

// File: rtl/rs_prio_enc.sv
// Lowest-set-bit priority encoder with an any-set flag.
module rs_prio_enc #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan from the top so the lowest requesting index wins.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_add_rs.sv
// Reservation station for the FP adder: dispatch, CDB snoop, issue into
// the external combinational adder, and a result stage held for the CDB.
module fp_add_rs
    import fp_rs_pkg::*;
#(
    parameter int ENTRIES = 4,
    parameter int TAG_W   = DEF_TAG_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               disp_valid,
    output logic               disp_ready,
    input  logic [TAG_W-1:0]   disp_tag,
    input  logic               disp_sub,
    input  logic [TAG_W-1:0]   disp_qj,
    input  logic [31:0]        disp_vj,
    input  logic [TAG_W-1:0]   disp_qk,
    input  logic [31:0]        disp_vk,
    input  logic               cdb_valid,
    input  logic [TAG_W-1:0]   cdb_tag,
    input  logic [31:0]        cdb_data,
    output logic [31:0]        fpa_a,
    output logic [31:0]        fpa_b,
    input  logic [31:0]        fpa_sum,
    output logic               res_valid,
    output logic [TAG_W-1:0]   res_tag,
    output logic [31:0]        res_data,
    input  logic               res_grant,
    output logic [ENTRIES-1:0] busy
);

    localparam int IDX_W  = $clog2(ENTRIES);
    localparam int STAGES = 1;

    rs_entry_t          slots [ENTRIES];
    logic [ENTRIES-1:0] rdy_vec;
    logic [IDX_W-1:0]   free_idx;
    logic [IDX_W-1:0]   rdy_idx;
    logic               free_any;
    logic               rdy_any;
    logic               accept;
    logic               adv;
    logic               issue_go;
    // [0] = issue stage (operands on fpa_a/fpa_b), [1] = result stage
    logic [STAGES:0]    vld_pipe;
    logic [TAG_W-1:0]   iss_tag;

    // Occupancy and readiness are both taken from the current state only.
    always_comb begin
        busy    = '0;
        rdy_vec = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            busy[i]    = slots[i].valid;
            rdy_vec[i] = slots[i].valid && (slots[i].qj == NO_TAG) &&
                         (slots[i].qk == NO_TAG);
        end
    end

    rs_prio_enc #(.N(ENTRIES), .IDX_W(IDX_W)) u_free_sel (
        .req (~busy),
        .idx (free_idx),
        .any (free_any)
    );

    rs_prio_enc #(.N(ENTRIES), .IDX_W(IDX_W)) u_rdy_sel (
        .req (rdy_vec),
        .idx (rdy_idx),
        .any (rdy_any)
    );

    assign disp_ready = free_any;
    assign accept     = disp_valid && free_any && (disp_tag != NO_TAG);
    // Result stage can take new data when empty or being drained by a grant.
    assign adv        = !vld_pipe[1] || res_grant;
    // Issue fills the issue stage when it is empty or moving forward.
    assign issue_go   = rdy_any && (!vld_pipe[0] || adv);
    assign res_valid  = vld_pipe[1];

    // Slot array: free on issue, fill on dispatch (with CDB bypass), snoop otherwise.
    // The issuing slot is valid and the dispatch slot is free, so they never collide.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                slots[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (issue_go && (rdy_idx == IDX_W'(i))) begin
                    slots[i].valid <= 1'b0;
                end else if (accept && (free_idx == IDX_W'(i))) begin
                    slots[i].valid <= 1'b1;
                    slots[i].tag   <= disp_tag;
                    slots[i].sub   <= disp_sub;
                    if (tag_hit(cdb_valid, cdb_tag, disp_qj)) begin
                        slots[i].qj <= NO_TAG;
                        slots[i].vj <= cdb_data;
                    end else begin
                        slots[i].qj <= disp_qj;
                        slots[i].vj <= disp_vj;
                    end
                    if (tag_hit(cdb_valid, cdb_tag, disp_qk)) begin
                        slots[i].qk <= NO_TAG;
                        slots[i].vk <= cdb_data;
                    end else begin
                        slots[i].qk <= disp_qk;
                        slots[i].vk <= disp_vk;
                    end
                end else if (slots[i].valid) begin
                    if (tag_hit(cdb_valid, cdb_tag, slots[i].qj)) begin
                        slots[i].qj <= NO_TAG;
                        slots[i].vj <= cdb_data;
                    end
                    if (tag_hit(cdb_valid, cdb_tag, slots[i].qk)) begin
                        slots[i].qk <= NO_TAG;
                        slots[i].vk <= cdb_data;
                    end
                end
            end
        end
    end

    // Issue and result stages; both freeze while the result waits for a grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            fpa_a    <= '0;
            fpa_b    <= '0;
            iss_tag  <= '0;
            res_tag  <= '0;
            res_data <= '0;
        end else begin
            if (adv) begin
                vld_pipe[1] <= vld_pipe[0];
                if (vld_pipe[0]) begin
                    res_tag  <= iss_tag;
                    res_data <= fpa_sum;
                end
            end
            if (issue_go) begin
                vld_pipe[0] <= 1'b1;
                fpa_a       <= slots[rdy_idx].vj;
                fpa_b       <= sign_flip(slots[rdy_idx].vk, slots[rdy_idx].sub);
                iss_tag     <= slots[rdy_idx].tag;
            end else if (adv) begin
                vld_pipe[0] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fp_add_rs.sv
// Bench for fp_add_rs: directed timing scenarios followed by randomized
// dispatch/CDB/grant traffic checked against an integer-valued FP model.
module tb_fp_add_rs;

    localparam int ENTRIES = 4;
    localparam int TAG_W   = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               disp_valid = 1'b0;
    logic               disp_ready;
    logic [TAG_W-1:0]   disp_tag = '0;
    logic               disp_sub = 1'b0;
    logic [TAG_W-1:0]   disp_qj = '0;
    logic [31:0]        disp_vj = '0;
    logic [TAG_W-1:0]   disp_qk = '0;
    logic [31:0]        disp_vk = '0;
    logic               cdb_valid = 1'b0;
    logic [TAG_W-1:0]   cdb_tag = '0;
    logic [31:0]        cdb_data = '0;
    logic [31:0]        fpa_a;
    logic [31:0]        fpa_b;
    logic [31:0]        fpa_sum;
    logic               res_valid;
    logic [TAG_W-1:0]   res_tag;
    logic [31:0]        res_data;
    logic               res_grant = 1'b0;
    logic [ENTRIES-1:0] busy;

    always #5 clk = ~clk;

    fp_add_rs #(.ENTRIES(ENTRIES), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_tag(disp_tag),
        .disp_sub(disp_sub), .disp_qj(disp_qj), .disp_vj(disp_vj),
        .disp_qk(disp_qk), .disp_vk(disp_vk),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .fpa_a(fpa_a), .fpa_b(fpa_b), .fpa_sum(fpa_sum),
        .res_valid(res_valid), .res_tag(res_tag), .res_data(res_data),
        .res_grant(res_grant), .busy(busy)
    );

    // Integer <-> single-precision conversion, exact for |x| < 2^24.
    function automatic logic [31:0] i2f(input int x);
        logic [31:0] r;
        int m;
        int p;
        if (x == 0) return 32'h0;
        m = (x < 0) ? -x : x;
        p = 0;
        while ((m >> (p + 1)) != 0) p++;
        r[31]    = (x < 0);
        r[30:23] = 8'(127 + p);
        r[22:0]  = 23'((m << (23 - p)) & 32'h007F_FFFF);
        return r;
    endfunction

    function automatic int f2i(input logic [31:0] b);
        int e;
        int m;
        int v;
        e = {24'b0, b[30:23]};
        if (e == 0) return 0;
        m = {8'b0, 1'b1, b[22:0]};
        if (e >= 150) v = m << (e - 150);
        else          v = m >> (150 - e);
        return b[31] ? -v : v;
    endfunction

    // External adder stand-in (operands are always integer-valued here).
    assign fpa_sum = i2f(f2i(fpa_a) + f2i(fpa_b));

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
    } exp_t;

    exp_t             sb[$];
    logic [TAG_W-1:0] granted[$];
    int               n_checks = 0;
    int               n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic bit sb_has(input logic [TAG_W-1:0] t);
        foreach (sb[i]) if (sb[i].tag == t) return 1'b1;
        return 1'b0;
    endfunction

    // Monitor: pops a matching expectation on every granted result and
    // checks that a waiting result stays frozen until it is granted.
    logic             hold_prev = 1'b0;
    logic [TAG_W-1:0] prev_tag  = '0;
    logic [31:0]      prev_data = '0;

    always @(negedge clk) begin
        int idx;
        if (rst_n && hold_prev) begin
            chk("hold_valid", 32'(res_valid), 32'd1);
            chk("hold_tag", 32'(res_tag), 32'(prev_tag));
            chk("hold_data", res_data, prev_data);
        end
        hold_prev = rst_n && res_valid && !res_grant;
        prev_tag  = res_tag;
        prev_data = res_data;
        if (rst_n && res_valid && res_grant) begin
            idx = -1;
            foreach (sb[i]) if (idx < 0 && sb[i].tag == res_tag) idx = i;
            granted.push_back(res_tag);
            if (idx < 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL result_tag: got unexpected tag %0d (data %h) at %0t",
                         res_tag, res_data, $time);
            end else begin
                chk("result_data", res_data, sb[idx].data);
                sb.delete(idx);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        disp_valid = 1'b0;
        cdb_valid  = 1'b0;
    endtask

    task automatic disp(input int tag, input bit sub, input int qj, input logic [31:0] vj,
                        input int qk, input logic [31:0] vk);
        disp_valid = 1'b1;
        disp_tag   = TAG_W'(tag);
        disp_sub   = sub;
        disp_qj    = TAG_W'(qj);
        disp_vj    = vj;
        disp_qk    = TAG_W'(qk);
        disp_vk    = vk;
    endtask

    task automatic push(input int tag, input int value);
        exp_t e;
        e.tag  = TAG_W'(tag);
        e.data = i2f(value);
        sb.push_back(e);
    endtask

    task automatic bcast(input int tag, input logic [31:0] data);
        cdb_valid = 1'b1;
        cdb_tag   = TAG_W'(tag);
        cdb_data  = data;
    endtask

    // Random phase state: external producer tags 8..15 with their future values.
    bit out_p[16];
    int val_p[16];

    task automatic pick_operand(output int q, output logic [31:0] v, output int val);
        int r;
        int lst[$];
        r   = $urandom_range(0, 3);
        val = int'($urandom_range(0, 2000)) - 1000;
        q   = 0;
        v   = i2f(val);
        if (r == 0) begin
            for (int p = 8; p < 16; p++) if (out_p[p]) lst.push_back(p);
            if (lst.size() > 0) begin
                q   = lst[$urandom_range(0, lst.size() - 1)];
                val = val_p[q];
                v   = $urandom;
            end
        end else if (r == 1) begin
            for (int p = 8; p < 16; p++) if (!out_p[p]) lst.push_back(p);
            if (lst.size() > 0) begin
                q        = lst[$urandom_range(0, lst.size() - 1)];
                out_p[q] = 1'b1;
                val_p[q] = val;
                v        = $urandom;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int qj, qk, vj_i, vk_i, t;
        logic [31:0] vj, vk;
        bit sub;
        int lst[$];
        int b;

        // ---------------- reset ----------------
        rst_n = 1'b0;
        res_grant = 1'b1;
        repeat (3) step();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_disp_ready", 32'(disp_ready), 32'd1);
        chk("reset_res_valid", 32'(res_valid), 32'd0);
        chk("reset_res_tag", 32'(res_tag), 32'd0);
        chk("reset_res_data", res_data, 32'd0);
        chk("reset_fpa_a", fpa_a, 32'd0);
        chk("reset_fpa_b", fpa_b, 32'd0);
        rst_n = 1'b1;
        step();

        // ---------------- add latency: 110 + 18 ----------------
        disp(3, 1'b0, 0, 32'h42DC0000, 0, 32'h41900000);
        push(3, 128);
        step(); idle();
        chk("add_busy_c1", 32'(busy), 32'b0001);
        chk("add_res_valid_c1", 32'(res_valid), 32'd0);
        step();
        chk("add_fpa_a_c2", fpa_a, 32'h42DC0000);
        chk("add_fpa_b_c2", fpa_b, 32'h41900000);
        chk("add_res_valid_c2", 32'(res_valid), 32'd0);
        step();
        chk("add_res_valid_c3", 32'(res_valid), 32'd1);
        chk("add_res_tag_c3", 32'(res_tag), 32'd3);
        chk("add_res_data_c3", res_data, 32'h43000000);

        // ---------------- sub: 110 - 18 ----------------
        disp(5, 1'b1, 0, 32'h42DC0000, 0, 32'h41900000);
        push(5, 92);
        step(); idle();
        step();
        chk("sub_fpa_b", fpa_b, 32'hC1900000);
        step();
        chk("sub_res_tag", 32'(res_tag), 32'd5);
        chk("sub_res_data", res_data, 32'h42B80000);

        // ---------------- wait on tag 7, resolved two cycles later ----------------
        disp(4, 1'b0, 7, 32'h0, 0, 32'h41900000);
        push(4, 128);
        step(); idle();
        chk("wait_busy_c1", 32'(busy), 32'b0001);
        step();
        chk("wait_busy_c2", 32'(busy), 32'b0001);
        chk("wait_no_issue_c2", 32'(res_valid), 32'd0);
        bcast(7, 32'h42DC0000);
        step(); idle();
        chk("wait_busy_after_capture", 32'(busy), 32'b0001);
        step();
        chk("wait_issued_busy", 32'(busy), 32'b0000);
        chk("wait_fpa_a", fpa_a, 32'h42DC0000);
        chk("wait_fpa_b", fpa_b, 32'h41900000);
        step();
        chk("wait_res_tag", 32'(res_tag), 32'd4);
        chk("wait_res_data", res_data, 32'h43000000);

        // ---------------- bypass: CDB tag 7 in the dispatch cycle ----------------
        disp(6, 1'b0, 7, 32'h0, 0, 32'h41900000);
        bcast(7, i2f(100));
        push(6, 118);
        step(); idle();
        step();
        chk("bypass_fpa_a", fpa_a, i2f(100));
        step();
        chk("bypass_res_tag", 32'(res_tag), 32'd6);
        chk("bypass_res_data", res_data, i2f(118));

        // ---------------- tag 0 dispatch is ignored ----------------
        step();
        disp(0, 1'b0, 0, i2f(1), 0, i2f(1));
        step(); idle();
        chk("tag0_busy", 32'(busy), 32'd0);
        repeat (3) step();
        chk("tag0_no_result", 32'(res_valid), 32'd0);

        // ---------------- full station ----------------
        for (int i = 1; i <= 4; i++) begin
            disp(i, 1'b0, 8 + i, 32'h0, 0, i2f(i));
            push(i, 11 * i);
            step();
        end
        idle();
        chk("full_disp_ready", 32'(disp_ready), 32'd0);
        chk("full_busy", 32'(busy), 32'b1111);
        disp(5, 1'b0, 0, i2f(1), 0, i2f(1));
        step(); idle();
        chk("full_ignored_busy", 32'(busy), 32'b1111);
        bcast(11, i2f(30));
        step(); idle();
        chk("full_busy_b1", 32'(busy), 32'b1111);
        chk("full_ready_b1", 32'(disp_ready), 32'd0);
        step();
        chk("full_busy_b2", 32'(busy), 32'b1011);
        chk("full_ready_b2", 32'(disp_ready), 32'd1);
        disp(7, 1'b0, 0, i2f(1), 0, i2f(2));
        push(7, 3);
        step(); idle();
        chk("full_refill_slot2", 32'(busy), 32'b1111);
        bcast(9, i2f(10));  step();
        bcast(10, i2f(20)); step();
        bcast(12, i2f(40)); step();
        idle();
        repeat (10) step();
        chk("full_drain_busy", 32'(busy), 32'd0);
        chk("full_drain_sb", 32'(sb.size()), 32'd0);

        // ---------------- backpressure and slot-index order ----------------
        res_grant = 1'b0;
        granted.delete();
        disp(2, 1'b0, 9, 32'h0, 0, i2f(5));
        push(2, 15);
        step();
        disp(1, 1'b1, 9, 32'h0, 0, i2f(3));
        push(1, 7);
        step(); idle();
        chk("bp_busy", 32'(busy), 32'b0011);
        bcast(9, i2f(10));
        step(); idle();
        step();
        step();
        for (int k = 0; k < 5; k++) begin
            chk("bp_res_valid", 32'(res_valid), 32'd1);
            chk("bp_res_tag", 32'(res_tag), 32'd2);
            chk("bp_res_data", res_data, i2f(15));
            chk("bp_fpa_a", fpa_a, i2f(10));
            chk("bp_fpa_b", fpa_b, 32'hC0400000);
            step();
        end
        res_grant = 1'b1;
        step();
        chk("bp_second_valid", 32'(res_valid), 32'd1);
        chk("bp_second_tag", 32'(res_tag), 32'd1);
        chk("bp_second_data", res_data, i2f(7));
        step();
        chk("bp_drained", 32'(res_valid), 32'd0);
        chk("bp_grant_count", 32'(granted.size()), 32'd2);
        if (granted.size() == 2) begin
            chk("bp_order_first", 32'(granted[0]), 32'd2);
            chk("bp_order_second", 32'(granted[1]), 32'd1);
        end

        // ---------------- reset mid-operation ----------------
        res_grant = 1'b0;
        disp(3, 1'b0, 0, i2f(1), 0, i2f(2));
        push(3, 3);
        step();
        disp(4, 1'b0, 0, i2f(3), 0, i2f(4));
        push(4, 7);
        step(); idle();
        disp(5, 1'b0, 12, 32'h0, 0, i2f(4));
        step(); idle();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        sb.delete();
        chk("mid_reset_res_valid", 32'(res_valid), 32'd0);
        chk("mid_reset_res_tag", 32'(res_tag), 32'd0);
        chk("mid_reset_res_data", res_data, 32'd0);
        chk("mid_reset_fpa_a", fpa_a, 32'd0);
        chk("mid_reset_fpa_b", fpa_b, 32'd0);
        chk("mid_reset_busy", 32'(busy), 32'd0);
        chk("mid_reset_ready", 32'(disp_ready), 32'd1);
        res_grant = 1'b1;
        bcast(12, i2f(1));
        step(); idle();
        repeat (4) begin
            step();
            chk("mid_reset_no_stale", 32'(res_valid), 32'd0);
        end

        // ---------------- randomized traffic ----------------
        for (int p = 0; p < 16; p++) out_p[p] = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            idle();
            cdb_tag   = TAG_W'($urandom);
            cdb_data  = $urandom;
            res_grant = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 9) < 6) begin
                if (disp_ready && $urandom_range(0, 19) != 0) begin
                    t = $urandom_range(1, 7);
                    for (int n = 0; n < 64 && sb_has(TAG_W'(t)); n++) t = $urandom_range(1, 7);
                    if (!sb_has(TAG_W'(t))) begin
                        pick_operand(qj, vj, vj_i);
                        pick_operand(qk, vk, vk_i);
                        sub = $urandom_range(0, 1);
                        disp(t, sub, qj, vj, qk, vk);
                        push(t, sub ? vj_i - vk_i : vj_i + vk_i);
                    end
                end else if (!disp_ready) begin
                    disp(1, 1'b0, 0, i2f(1), 0, i2f(1));
                end else begin
                    disp(0, 1'b0, 0, i2f(1), 0, i2f(1));
                end
            end
            b = $urandom_range(0, 9);
            lst.delete();
            for (int p = 8; p < 16; p++) if (out_p[p]) lst.push_back(p);
            if (b < 3 && lst.size() > 0) begin
                t = lst[$urandom_range(0, lst.size() - 1)];
                bcast(t, i2f(val_p[t]));
                out_p[t] = 1'b0;
            end else if (b == 3) begin
                lst.delete();
                lst.push_back(0);
                for (int p = 8; p < 16; p++) if (!out_p[p]) lst.push_back(p);
                bcast(lst[$urandom_range(0, lst.size() - 1)], $urandom);
            end
            step();
        end

        // ---------------- drain ----------------
        idle();
        res_grant = 1'b1;
        for (int p = 8; p < 16; p++) begin
            if (out_p[p]) begin
                bcast(p, i2f(val_p[p]));
                out_p[p] = 1'b0;
                step();
            end
        end
        idle();
        for (int n = 0; n < 300 && sb.size() != 0; n++) step();
        chk("final_drain_sb", 32'(sb.size()), 32'd0);
        chk("final_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fp_add_rs.md
Name: fp_add_rs

Overview:
Reservation station and issue/writeback control for the floating-point adder unit in the Tomasulo datapath. It accepts dispatched add/sub operations whose operands are either values or producer tags. It snoops the common data bus (CDB) to resolve tags, drives operand pairs into the external combinational 32-bit FP adder, and captures the sum. It then requests the CDB to broadcast the result under its destination tag.

Parameters:
ENTRIES, 4, number of reservation-station slots (2..16)
TAG_W, 4, width of producer/destination tags; tag 0 is reserved as "no tag / value valid"

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset, synchronous, active-low
disp_valid  in  1  dispatch request
disp_ready  out  1  at least one free slot in current state
disp_tag  in  TAG_W  destination tag of the operation; must be nonzero
disp_sub  in  1  1 = compute vj - vk, 0 = vj + vk
disp_qj  in  TAG_W  producer tag of operand j; 0 = disp_vj valid
disp_vj  in  32  operand j value (IEEE-754 single)
disp_qk  in  TAG_W  producer tag of operand k; 0 = disp_vk valid
disp_vk  in  32  operand k value
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  TAG_W  CDB broadcast tag
cdb_data  in  32  CDB broadcast value
fpa_a  out  32  adder operand a (registered)
fpa_b  out  32  adder operand b (registered, sign pre-flipped for sub)
fpa_sum  in  32  adder combinational result of fpa_a + fpa_b
res_valid  out  1  result waiting for CDB
res_tag  out  TAG_W  destination tag of result
res_data  out  32  result value
res_grant  in  1  CDB arbiter accepts result this cycle
busy  out  ENTRIES  per-slot occupied bits

Behaviour:
- Reset (rst_n low at edge): all slots invalid. busy=0, disp_ready=1, res_valid=0, res_tag=0, res_data=0, fpa_a=0, fpa_b=0, issue stage empty. In-flight operations are discarded.
- Slot fields: valid, tag, sub, qj, vj, qk, vk.
- Dispatch: accepted when disp_valid && disp_ready && disp_tag!=0. Written into the lowest-index free slot of the current state. A slot freed in the same cycle is not reused until the next cycle. disp_valid with disp_ready=0, or with disp_tag=0, is ignored with no state change.
- Dispatch bypass: if cdb_valid and cdb_tag==disp_qj!=0 in the accept cycle, store vj=cdb_data and qj=0. Same rule for k.
- Snoop: each cycle, for every valid slot with qj!=0 && cdb_valid && cdb_tag==qj, set vj<=cdb_data and qj<=0. Same for k; both operands may resolve in one cycle.
- Ready: a slot is ready when valid && qj==0 && qk==0, evaluated on current state.
- Issue: the lowest-index ready slot moves to the issue stage when the stage is empty or advancing this cycle. On issue: fpa_a<=vj, fpa_b<={vk[31]^sub, vk[30:0]}, slot freed.
- Result stage: the issue stage advances when res_valid==0 or res_grant==1. It loads res_data<=fpa_sum and res_tag<=issue tag, and sets res_valid=1. res_tag and res_data hold stable until the grant cycle. After a grant with nothing advancing, res_valid<=0. res_grant while res_valid==0 is ignored.
- Backpressure: while res_valid=1 and no grant, the issue stage holds, fpa_a/fpa_b stay stable, and no new issue occurs.
- Latency: dispatch accepted in cycle 0 with both operands valid -> fpa_a/fpa_b valid in cycle 2 -> res_valid in cycle 3. Sustained throughput is 1 result/cycle with res_grant tied high.
- Full: disp_ready=0 iff all ENTRIES slots are valid.

Decomposition:
- Package fp_rs_pkg: TAG_W default, NO_TAG=0, FP_SIGN_BIT=31, rs_entry_t struct (valid, tag, sub, qj, vj, qk, vk).
- Sub-module rs_prio_enc (lowest-set-bit index + any flag). Instantiated twice: free-slot select and ready-slot select.
- FP adder stays external.

Test Plan:
- Reset, then dispatch tag=3, sub=0, qj=qk=0, vj=0x42DC0000 (110.0), vk=0x41900000 (18.0) -> res_valid in cycle 3 with res_tag=3, res_data=0x43000000 (128.0).
- Same operands with sub=1, tag=5 -> fpa_b=0xC1900000; res_data=0x42B80000 (92.0).
- Dispatch qj=7, vk ready; CDB tag=7 data=0x42DC0000 two cycles later -> issue the cycle after capture; no issue before. CDB tag 7 in the dispatch cycle itself -> bypass captures it.
- Dispatch 4 ops with unresolved tags -> disp_ready=0, busy=4'b1111; 5th disp_valid ignored; resolve slot 2 -> it issues, disp_ready=1 next cycle, next dispatch lands in slot 2.
- res_grant low 5 cycles with two ready ops -> res_valid/res_tag/res_data and fpa_a/fpa_b frozen; grant -> results emerge in slot-index order on consecutive grants.
- rst_n low for one cycle mid-operation -> all outputs at reset values next cycle; no stale result broadcast afterward.
